// File: rtl/prio_deco_hold.sv
// Registered 2-to-4 decoder that holds the decoded one-hot line for a programmable number of cycles.
// Optional per-line accept counters are compiled in with `define PRIO_DECO_STATS_EN.
module prio_deco_hold #(
  parameter int HOLD_W = 4,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_idx,
  input  logic [HOLD_W-1:0] hold_len,
  output logic [3:0]        Y,
  output logic              out_valid
`ifdef PRIO_DECO_STATS_EN
  ,
  output logic [4*CNT_W-1:0] evt_cnt
`endif
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;

  logic [0:0]        state_reg;
  logic [HOLD_W-1:0] cnt_reg;
  logic [3:0]        y_reg;
  logic              out_valid_reg;
  logic [3:0]        dec;
  logic [HOLD_W-1:0] cnt_load;
  logic              accept;

  // Keeps CNT_W referenced in builds without the counters.
  if (CNT_W < 1) begin : g_cnt_w_unused
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_dec
    assign dec[gi] = (in_idx == gi[1:0]);
  end

  // hold_len of 0 behaves as 1, so both load a zero remaining count.
  assign cnt_load = (hold_len == '0) ? '0 : hold_len - 1'b1;

  assign in_ready  = rst_n && ((state_reg == IDLE) || (cnt_reg == '0));
  assign accept    = in_valid && in_ready;
  assign Y         = y_reg;
  assign out_valid = out_valid_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      y_reg         <= '0;
      out_valid_reg <= 1'b0;
    end else if (accept) begin
      state_reg     <= HOLD;
      cnt_reg       <= cnt_load;
      y_reg         <= dec;
      out_valid_reg <= 1'b1;
    end else if (state_reg == HOLD) begin
      if (cnt_reg != '0) begin
        cnt_reg <= cnt_reg - 1'b1;
      end else begin
        state_reg     <= IDLE;
        y_reg         <= '0;
        out_valid_reg <= 1'b0;
      end
    end
  end

`ifdef PRIO_DECO_STATS_EN
  logic [CNT_W-1:0] evt_reg [4];

  for (genvar gi = 0; gi < 4; gi++) begin : g_stats
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        evt_reg[gi] <= '0;
      end else if (accept && dec[gi] && (evt_reg[gi] != '1)) begin
        evt_reg[gi] <= evt_reg[gi] + 1'b1;
      end
    end
    assign evt_cnt[gi*CNT_W +: CNT_W] = evt_reg[gi];
  end
`endif

endmodule
